red_pitaya_dac_slew: RTL
========================

Name: red_pitaya_dac_slew

Overview:
Per-channel DAC output conditioning stage placed directly downstream of the ASG channel. It takes the channel's 14-bit scaled/offset sample stream and applies a programmable slew-rate limit, then a soft enable/disable gain fade, before the DAC interface. This prevents output steps on waveform start, stop and reconfiguration. It also counts the number of cycles in which slew limiting was active.

Parameters:
DW, 14, sample width (signed two's complement); only 14 is supported.
GW, 14, fade gain width, unsigned; unity gain = 2^(GW-1) = 8192.

Ports:
dac_clk_i  in  1  DAC clock; all logic is on the rising edge.
dac_rstn_i  in  1  Reset, asynchronous assert, active low.
dac_i  in  DW  Signed sample from the ASG channel, valid every cycle.
set_en_i  in  1  Output enable request; level-sensitive.
set_slew_i  in  DW  Unsigned max |step| per cycle; 0 = limiter bypassed.
set_fade_step_i  in  GW  Gain increment/decrement per cycle during fades; 0 = instant switch.
set_clr_i  in  1  Synchronous clear of lim_cnt_o.
dac_o  out  DW  Conditioned signed sample to the DAC.
state_o  out  2  0 = OFF, 1 = FADE_IN, 2 = ON, 3 = FADE_OUT.
gain_o  out  GW  Current fade gain, 0 to 8192.
lim_cnt_o  out  32  Count of cycles in which slew limiting was active.

Behaviour:
- Reset (async, dac_rstn_i = 0): slew register s = 0, gain = 0, state = OFF, all pipeline regs = 0, dac_o = 0, lim_cnt_o = 0. Normal operation resumes on the first clock edge after deassertion.
- Stage 1, slew:
  - diff = dac_i - s, computed 15-bit signed.
  - If set_slew_i == 0 or |diff| <= set_slew_i: s <= dac_i, and the cycle is not limited.
  - Else: s <= s + set_slew_i if diff > 0, s <= s - set_slew_i if diff < 0; the cycle is limited. The result never passes dac_i, so no overflow.
  - s updates every cycle in every state, so it tracks the input even while OFF.
- Stage 2, gain multiply: m <= s * {1'b0, gain}, 28-bit signed, using the gain value present at this edge.
- Stage 3, output: dac_o <= m[26:13], arithmetic shift right by 13.
  - Gain <= 8192 guarantees |result| <= |s|, so no saturation is needed.
  - At gain 8192, dac_o equals s exactly. A negative input at partial gain rounds toward minus infinity.
- Latency: dac_i to dac_o is 3 cycles with the limiter inactive and state ON.
- Fade FSM (state and gain update on the same edge):
  - OFF: gain = 0. If set_en_i, go to FADE_IN.
  - FADE_IN: gain <= min(gain + step, 8192), where the sum is computed 15-bit.
    - If the new gain is 8192, go to ON in the same edge.
    - If set_en_i = 0, go to FADE_OUT with gain unchanged that cycle.
  - ON: gain = 8192. If set_en_i = 0, go to FADE_OUT.
  - FADE_OUT: gain <= max(gain - step, 0).
    - If the new gain is 0, go to OFF in the same edge.
    - If set_en_i = 1, go to FADE_IN with gain unchanged that cycle.
  - step == 0: the entry edge into FADE_IN sets gain = 8192 and goes to ON directly. Entry into FADE_OUT sets gain = 0 and goes to OFF directly. The FADE states are never visible on state_o.
  - set_fade_step_i is sampled every cycle; a change mid-fade takes effect on the next edge.
- lim_cnt_o:
  - Increments on each limited cycle and saturates at 0xFFFFFFFF.
  - set_clr_i takes priority and loads 0, including when a limited cycle coincides with the clear.
- Status timing: state_o and gain_o are registered and reflect the FSM directly. gain_o leads its effect on dac_o by 2 cycles.
- set_slew_i changes are allowed at any time and apply from the next edge. Limiting is always toward the current dac_i.

Test Plan:
1. Bypass: set_en_i = 1, step = 0, set_slew_i = 0, dac_i ramps 0,1,2,... -> state_o goes to 2 after 1 edge; dac_o equals dac_i delayed 3 cycles; lim_cnt_o stays 0.
2. Slew limit: ON, set_slew_i = 1000, dac_i steps 0 -> 8191 -> s reaches 8000 after 8 cycles and 8191 on the 9th; lim_cnt_o = 8.
3. Negative slew: ON, set_slew_i = 1000, dac_i steps 8191 -> -8192 -> s = 7191, ..., -7809, then -8192 in 17 cycles; lim_cnt_o = 16.
4. Fade in/out: dac_i = 4096, step = 1024, set_en_i rises:
   - gain_o runs 1024 ... 8192 over 8 cycles, then state ON; dac_o runs 512, 1024, ..., 4096.
   - Deassert set_en_i -> gain falls to 0 in 8 cycles, state OFF, dac_o = 0.
5. Fade reversal: step = 1000, deassert set_en_i at gain = 3000 -> state 3, gain holds 3000 for one cycle, then 2000, 1000, 0, then OFF. Re-assert set_en_i at gain 1000 -> FADE_IN from 1000.
6. Reset and clear:
   - Assert dac_rstn_i mid-FADE_IN with lim_cnt_o = 5 -> dac_o, gain_o, state_o and lim_cnt_o read 0 immediately, without waiting for a clock.
   - set_clr_i together with a limited cycle -> lim_cnt_o = 0.
   - Force lim_cnt_o to 0xFFFFFFFF -> it stays saturated.

Source files
------------

// File: rtl/red_pitaya_dac_slew.sv
// red_pitaya_dac_slew: per-channel DAC conditioning with slew-rate limit and soft enable/disable gain fade.
module red_pitaya_dac_slew #(
    parameter int DW = 14,
    parameter int GW = 14
) (
    input  logic          dac_clk_i,
    input  logic          dac_rstn_i,
    input  logic [DW-1:0] dac_i,
    input  logic          set_en_i,
    input  logic [DW-1:0] set_slew_i,
    input  logic [GW-1:0] set_fade_step_i,
    input  logic          set_clr_i,
    output logic [DW-1:0] dac_o,
    output logic [1:0]    state_o,
    output logic [GW-1:0] gain_o,
    output logic [31:0]   lim_cnt_o
);
    typedef enum logic [1:0] {OFF, FADE_IN, ON, FADE_OUT} state_t;
    localparam logic [GW-1:0] UNITY = {1'b1, {(GW-1){1'b0}}};
    state_t                    state, state_nxt;
    logic        [GW-1:0]      gain, gain_nxt;
    logic signed [DW-1:0]      s, s_nxt;
    logic signed [DW:0]        diff, mag;
    logic signed [DW+GW:0]     prod;
    logic signed [DW+GW-1:0]   m;
    logic        [GW:0]        sum;
    logic                      limited, zs, up_done, dn_done;
    logic        [31:0]        lim_cnt;
    assign diff    = $signed({dac_i[DW-1], dac_i}) - $signed({s[DW-1], s});
    assign mag     = diff[DW] ? -diff : diff;
    assign limited = (set_slew_i != '0) && ($unsigned(mag) > {1'b0, set_slew_i});
    // the limited step never overshoots dac_i, so the truncated sum cannot wrap
    assign s_nxt   = !limited ? dac_i : diff[DW] ? s - set_slew_i : s + set_slew_i;
    assign prod    = s * $signed({1'b0, gain});
    assign sum     = {1'b0, gain} + {1'b0, set_fade_step_i};
    assign zs      = set_fade_step_i == '0;
    assign up_done = zs || (sum >= {1'b0, UNITY});
    assign dn_done = zs || (gain <= set_fade_step_i);
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        case (state)
            OFF: begin
                state_nxt = !set_en_i ? OFF : zs ? ON : FADE_IN;
                gain_nxt  = (set_en_i && zs) ? UNITY : '0;
            end
            FADE_IN: begin
                state_nxt = !set_en_i ? (zs ? OFF : FADE_OUT) : (up_done ? ON : FADE_IN);
                gain_nxt  = !set_en_i ? (zs ? '0 : gain) : (up_done ? UNITY : sum[GW-1:0]);
            end
            ON: begin
                state_nxt = set_en_i ? ON : zs ? OFF : FADE_OUT;
                gain_nxt  = (set_en_i || !zs) ? UNITY : '0;
            end
            default: begin
                state_nxt = set_en_i ? (zs ? ON : FADE_IN) : (dn_done ? OFF : FADE_OUT);
                gain_nxt  = set_en_i ? (zs ? UNITY : gain) : (dn_done ? '0 : gain - set_fade_step_i);
            end
        endcase
    end
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state   <= OFF;
            gain    <= '0;
            s       <= '0;
            m       <= '0;
            dac_o   <= '0;
            lim_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gain    <= gain_nxt;
            s       <= s_nxt;
            m       <= prod[DW+GW-1:0];
            dac_o   <= m[DW+GW-2:GW-1];
            lim_cnt <= set_clr_i ? '0 : lim_cnt + 32'(limited && ~&lim_cnt);
        end
    end
    assign state_o   = state;
    assign gain_o    = gain;
    assign lim_cnt_o = lim_cnt;
endmodule
